instr_mem_responder: RTL and testbench

- Memory-side responder for the instruction fetch protocol (req/addr → gnt → r_valid/r_rdata) driven by the core's fetch interface.
- Backed by a word-addressed instruction array, preloaded through a write port.
- Provides programmable grant wait states and a fixed read latency, so the fetch interface can be exercised against realistic memory timing.
- Pipelined: accepts a new request in every grant cycle, and responses return in order.

---
 rtl/instr_mem_responder.sv | 158 +++++++++++++++
 tb/tb_instr_mem_responder.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_responder.sv
// Instruction-fetch memory responder: grant after GNT_WAIT_CYCLES, r_valid RVALID_LATENCY cycles later, no r_valid backpressure.
// Define INSTR_RESP_RAND_GNT_EN to let a 16-bit LFSR withhold otherwise-grantable cycles.
module instr_mem_responder #(
  parameter int          ADDR_WIDTH      = 10,
  parameter int          GNT_WAIT_CYCLES = 0,
  parameter int          RVALID_LATENCY  = 1,
  parameter logic [31:0] OOR_DATA        = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_req_i,
  input  logic [31:0]           instr_addr_i,
  output logic                  instr_gnt_o,
  output logic                  instr_r_valid_o,
  output logic [31:0]           instr_r_rdata_o,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [31:0]           wr_data_i,
  output logic                  protocol_err_o
);

  localparam int CNT_W = (GNT_WAIT_CYCLES < 1) ? 1 : $clog2(GNT_WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(GNT_WAIT_CYCLES);

  typedef enum logic {IDLE, WAIT_GNT} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [31:0]           addr_q, addr_d;
  logic                  err_q, err_set;
  logic                  gnt;
  logic                  hold_gnt;
  logic                  oor;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic [31:0]           rd_data;

  logic [31:0] mem [0:2**ADDR_WIDTH-1];

`ifdef INSTR_RESP_RAND_GNT_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign hold_gnt = lfsr_q[0];
`else
  assign hold_gnt = 1'b0;
`endif

  // Upper address bits beyond the array select the out-of-range response.
  generate
    if (ADDR_WIDTH < 30) begin : g_oor
      assign oor = |instr_addr_i[31:ADDR_WIDTH+2];
    end else begin : g_no_oor
      assign oor = 1'b0;
    end
  endgenerate

  assign rd_idx  = instr_addr_i[ADDR_WIDTH+1:2];
  assign rd_data = oor ? OOR_DATA : mem[rd_idx];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    gnt     = 1'b0;
    err_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (instr_req_i) begin
          if (GNT_WAIT_CYCLES == 0 && !hold_gnt) begin
            gnt = 1'b1;
          end else begin
            state_d = WAIT_GNT;
            addr_d  = instr_addr_i;
            cnt_d   = (GNT_WAIT_CYCLES == 0) ? CNT_MAX : CNT_W'(1);
          end
        end
      end
      WAIT_GNT: begin
        if (!instr_req_i) begin
          state_d = IDLE;
          err_set = 1'b1;
        end else begin
          // An address change is flagged, but the grant still uses the live address.
          if (instr_addr_i != addr_q) begin
            err_set = 1'b1;
          end
          if (cnt_q == CNT_MAX) begin
            if (!hold_gnt) begin
              gnt     = 1'b1;
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      err_q   <= err_q | err_set;
    end
  end

  // Preload port; a same-cycle granted read sees the pre-write contents.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
  end

  logic [RVALID_LATENCY-1:0] vld_q;
  logic [31:0]               dat_q [RVALID_LATENCY];

  // Data stages only advance behind a valid, so the output holds between responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < RVALID_LATENCY; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= gnt;
      if (gnt) begin
        dat_q[0] <= rd_data;
      end
      for (int i = 1; i < RVALID_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          dat_q[i] <= dat_q[i-1];
        end
      end
    end
  end

  assign instr_gnt_o     = gnt;
  assign instr_r_valid_o = vld_q[RVALID_LATENCY-1];
  assign instr_r_rdata_o = dat_q[RVALID_LATENCY-1];
  assign protocol_err_o  = err_q;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Scoreboard bench for instr_mem_responder: a default instance and a wait-state/long-latency instance.
`timescale 1ns/1ps
module tb_instr_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [1:0]       req, gnt, rv, err;
  logic [1:0][31:0] addr, rd;
  logic             wr_en;
  logic [9:0]       wr_addr;
  logic [31:0]      wr_data;

  instr_mem_responder u_dut0 (
    .clk(clk), .rst(rst),
    .instr_req_i(req[0]), .instr_addr_i(addr[0]), .instr_gnt_o(gnt[0]),
    .instr_r_valid_o(rv[0]), .instr_r_rdata_o(rd[0]),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .protocol_err_o(err[0])
  );

  instr_mem_responder #(.GNT_WAIT_CYCLES(2), .RVALID_LATENCY(4), .OOR_DATA(32'hDEAD_BEEF)) u_dut1 (
    .clk(clk), .rst(rst),
    .instr_req_i(req[1]), .instr_addr_i(addr[1]), .instr_gnt_o(gnt[1]),
    .instr_r_valid_o(rv[1]), .instr_r_rdata_o(rd[1]),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .protocol_err_o(err[1])
  );

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] mdl [0:1023];
  int          cyc    = 0;
  int          tests  = 0;
  int          fails  = 0;
  bit          mon_en = 1'b0;
  bit          fw_en;
  logic [9:0]  fw_idx;
  logic [31:0] fw_data;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int gw(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic logic [31:0] oor(input int d);
    return (d == 0) ? 32'h0000_0000 : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] exp_data(input int d, input logic [31:0] a);
    if (a[31:12] != 20'd0) return oor(d);
    return mdl[a[11:2]];
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    if ($urandom_range(0, 7) == 0) begin
      a = $urandom;
      if (a[31:12] == 20'd0) a[12] = 1'b1;
    end else begin
      a = 32'($urandom_range(0, 63)) * 32'd4 + 32'($urandom_range(0, 3));
    end
    return a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int d, input int due, input logic [31:0] data);
    exp_t e;
    e.due  = due;
    e.data = data;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic mon(input int d, input logic v, input logic [31:0] data);
    exp_t e;
    bit   have;
    have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
    if (have) begin
      if (d == 0) e = q0[0];
      else        e = q1[0];
    end
    if (v) begin
      if (!have) begin
        tests++; fails++;
        $display("FAIL rvalid_unexpected%0d: got r_valid=1 data %h, expected r_valid=0 (cycle %0d)", d, data, cyc);
      end else begin
        if (d == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
        chk($sformatf("rvalid_cycle%0d", d), cyc, e.due);
        chk($sformatf("rdata%0d", d), data, e.data);
      end
    end else if (have && e.due <= cyc) begin
      tests++; fails++;
      $display("FAIL rvalid_missing%0d: got r_valid=0, expected r_valid=1 data %h (cycle %0d)", d, e.data, cyc);
      if (d == 0) void'(q0.pop_front());
      else        void'(q1.pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, rv[0], rd[0]);
      mon(1, rv[1], rd[1]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    req   = '0;
    wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wr(input int idx, input logic [31:0] d);
    step();
    wr_en   = 1'b1;
    wr_addr = 10'(idx);
    wr_data = d;
    mdl[idx] = d;
  endtask

  // Holds req for the wait-state count plus one cycle; the last cycle is the grant.
  task automatic issue(input int d, input logic [31:0] a, input logic [31:0] a2, input bit rand_wr);
    int          wi;
    logic [31:0] wd;
    for (int k = 0; k <= gw(d); k++) begin
      step();
      req[d]  = 1'b1;
      addr[d] = (k == 0) ? a : a2;
      if (k == gw(d)) push(d, cyc + lat(d), exp_data(d, addr[d]));
      if (fw_en && k == gw(d)) begin
        wr_en = 1'b1; wr_addr = fw_idx; wr_data = fw_data;
        mdl[fw_idx] = fw_data;
        fw_en = 1'b0;
      end else if (rand_wr && $urandom_range(0, 3) == 0) begin
        wi = $urandom_range(0, 63);
        wd = $urandom;
        wr_en = 1'b1; wr_addr = 10'(wi); wr_data = wd;
        mdl[wi] = wd;
      end
      @(negedge clk);
      chk($sformatf("gnt%0d_k%0d", d, k), {31'd0, gnt[d]}, {31'd0, k == gw(d)});
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_gnt%0d", tag, d), {31'd0, gnt[d]}, 32'd0);
      chk($sformatf("%s_rvalid%0d", tag, d), {31'd0, rv[d]}, 32'd0);
      chk($sformatf("%s_rdata%0d", tag, d), rd[d], 32'd0);
      chk($sformatf("%s_err%0d", tag, d), {31'd0, err[d]}, 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, expected completion within 2 ms");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int          n;
    rst = 1'b1; req = '0; addr = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    fw_en = 1'b0; fw_idx = '0; fw_data = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk_zero_outputs("reset");
    step();
    rst    = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 64; i++) wr(i, $urandom);
    for (int i = 0; i < 4; i++) wr(i, 32'h1000_0000 + 32'(i));
    wr(4, 32'h4444_0004);
    wr(5, 32'h0000_0000);

    // Back-to-back fetches with no wait states.
    issue(0, 32'h0, 32'h0, 1'b0);
    issue(0, 32'h4, 32'h4, 1'b0);
    issue(0, 32'h8, 32'h8, 1'b0);
    issue(0, 32'hC, 32'hC, 1'b0);
    idle(3);

    issue(1, 32'h10, 32'h10, 1'b0);
    idle(6);

    issue(0, 32'h0000_1000, 32'h0000_1000, 1'b0);
    issue(1, 32'h0000_1000, 32'h0000_1000, 1'b0);
    idle(6);
    @(negedge clk);
    chk("oor_err0", {31'd0, err[0]}, 32'd0);
    chk("oor_err1", {31'd0, err[1]}, 32'd0);

    // Write and granted read to the same word in one cycle.
    fw_en = 1'b1; fw_idx = 10'd5; fw_data = 32'hCAFE_F00D;
    issue(0, 32'h14, 32'h14, 1'b0);
    issue(0, 32'h14, 32'h14, 1'b0);
    idle(3);

    // Request withdrawn before the grant.
    step(); req[1] = 1'b1; addr[1] = 32'h20;
    @(negedge clk);
    chk("drop_gnt_c0", {31'd0, gnt[1]}, 32'd0);
    step();
    @(negedge clk);
    chk("drop_gnt_c1", {31'd0, gnt[1]}, 32'd0);
    chk("drop_err_c1", {31'd0, err[1]}, 32'd0);
    step();
    @(negedge clk);
    chk("drop_err_c2", {31'd0, err[1]}, 32'd1);
    idle(4);
    @(negedge clk);
    chk("drop_err_sticky", {31'd0, err[1]}, 32'd1);
    chk("drop_err_other", {31'd0, err[0]}, 32'd0);

    // Reset with a response still in flight.
    issue(1, 32'h0, 32'h0, 1'b0);
    issue(1, 32'h4, 32'h4, 1'b0);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    q0.delete();
    q1.delete();
    @(negedge clk);
    chk_zero_outputs("post_rst");
    idle(8);

    for (int b = 0; b < 200; b++) begin
      n = $urandom_range(1, 6);
      for (int j = 0; j < n; j++) begin
        a = rand_addr();
        issue(0, a, a, 1'b1);
      end
      idle($urandom_range(0, 2));
    end
    for (int b = 0; b < 60; b++) begin
      n = $urandom_range(1, 4);
      for (int j = 0; j < n; j++) begin
        a = rand_addr();
        issue(1, a, a, 1'b1);
      end
      idle($urandom_range(0, 2));
    end
    idle(6);
    @(negedge clk);
    chk("rand_err0", {31'd0, err[0]}, 32'd0);
    chk("rand_err1", {31'd0, err[1]}, 32'd0);

    // Address changed while waiting: flagged, grant uses the new address.
    issue(1, 32'h8, 32'hC, 1'b0);
    step();
    @(negedge clk);
    chk("addr_change_err", {31'd0, err[1]}, 32'd1);
    idle(10);
    @(negedge clk);
    chk("drain_q0", q0.size(), 32'd0);
    chk("drain_q1", q1.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
